// File: rtl/sensor_event_arbiter_pkg.sv
// rtl/sensor_event_arbiter_pkg.sv - Shared types, constants and round-robin helper for the sensor event arbiter
package sensor_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int CNT_W = 8;

  // Index of the first set request at or after ptr, wrapping modulo n (n <= 16).
  function automatic int rr_pick(input logic [15:0] req, input int n, input int ptr);
    int pick;
    int idx;
    pick = 0;
    for (int i = 15; i >= 0; i--) begin
      idx = (ptr + i) % n;
      if (i < n && req[idx[3:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sensor_event_arbiter_if.sv
// rtl/sensor_event_arbiter_if.sv - Valid/ready event channel between arbiter and consumer
interface sensor_event_arbiter_if #(
  parameter int N_CH = 4
) ();
  localparam int CW = $clog2(N_CH);

  logic          evt_valid;
  logic [CW-1:0] evt_ch;
  logic          evt_level;
  logic          evt_ready;

  modport master (output evt_valid, output evt_ch, output evt_level, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_level, output evt_ready);
endinterface

// File: rtl/sensor_event_arbiter_debounce.sv
// rtl/sensor_event_arbiter_debounce.sv - Per-channel two-flop synchronizer and counting debouncer
module sensor_debounce
  import sensor_arb_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic CLK,
  input  logic MR,
  input  logic x,
  output logic stable,
  output logic flip
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // flip is asserted in the cycle whose closing edge toggles stable, so the
  // arbiter can latch the event on the same edge the level changes.
  assign flip = (sync2 != stable) && (cnt == LAST);

  // Synchronize the raw line, then count consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= x;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_event_arbiter.sv
// rtl/sensor_event_arbiter.sv - Debounced sensor change events, served round-robin over valid/ready
module sensor_event_arbiter
  import sensor_arb_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 3
) (
  input  logic                   CLK,
  input  logic                   MR,
  input  logic [N_CH-1:0]        x,
  input  logic [N_CH-1:0]        en_mask,
  input  logic                   ovf_clr,
  output logic                   z,
  output logic                   overflow,
  sensor_event_arbiter_if.master evt
);

  localparam int CW = $clog2(N_CH);

  state_t          state;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] flip;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] pend_nxt;
  logic [N_CH-1:0] req;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   grant;
  logic            hs;
  logic            offering;
  logic            ovf_set;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .CLK    (CLK),
      .MR     (MR),
      .x      (x[c]),
      .stable (stable[c]),
      .flip   (flip[c])
    );
  end

  assign hs       = evt.evt_valid & evt.evt_ready;
  assign offering = (state == OFFER);
  assign req      = pending & en_mask;
  assign grant    = CW'(rr_pick(16'(req), N_CH, int'(ptr)));

  // Next pending set and overflow detection; a new flip outranks both the
  // mask clear and the handshake clear so no change is silently dropped.
  always_comb begin
    pend_nxt = pending;
    ovf_set  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (!en_mask[c] && !(offering && evt.evt_ch == CW'(c))) pend_nxt[c] = 1'b0;
      if (hs && evt.evt_ch == CW'(c)) pend_nxt[c] = 1'b0;
      if (flip[c] && en_mask[c]) begin
        pend_nxt[c] = 1'b1;
        if (pending[c] && !(hs && evt.evt_ch == CW'(c))) ovf_set = 1'b1;
      end
    end
  end

  // Pending events, sticky overflow (set beats clear) and registered status.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      pending  <= '0;
      overflow <= 1'b0;
      z        <= 1'b0;
    end else begin
      pending <= pend_nxt;
      z       <= |(stable & en_mask);
      if (ovf_set) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Offer FSM: grant one pending channel, hold it stable until accepted.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state         <= IDLE;
      evt.evt_valid <= 1'b0;
      evt.evt_ch    <= '0;
      evt.evt_level <= 1'b0;
      ptr           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            evt.evt_ch    <= grant;
            evt.evt_level <= stable[grant];
            evt.evt_valid <= 1'b1;
            state         <= OFFER;
          end
        end
        OFFER: begin
          if (evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
            ptr           <= (evt.evt_ch == CW'(N_CH - 1)) ? '0 : evt.evt_ch + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_event_arbiter.sv
// tb/tb_sensor_event_arbiter.sv - Self-checking bench for sensor_event_arbiter
module tb_sensor_event_arbiter;
  localparam int N_CH       = 4;
  localparam int DEB_CYCLES = 3;

  logic       CLK = 1'b0;
  logic       MR;
  logic [3:0] x;
  logic [3:0] en_mask;
  logic       ovf_clr;
  logic       z;
  logic       overflow;

  sensor_event_arbiter_if #(.N_CH(N_CH)) evt ();

  sensor_event_arbiter #(.N_CH(N_CH), .DEB_CYCLES(DEB_CYCLES)) dut (
    .CLK      (CLK),
    .MR       (MR),
    .x        (x),
    .en_mask  (en_mask),
    .ovf_clr  (ovf_clr),
    .z        (z),
    .overflow (overflow),
    .evt      (evt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] mask;
    logic       rdy;
    logic       v;
    logic [1:0] ch;
    logic       lvl;
    logic       z;
    logic       ovf;
  } vec_t;

  vec_t tab_a[8];
  vec_t tab_b[23];

  function automatic vec_t mk(input logic [3:0] xi, input logic [3:0] m, input logic r,
                              input logic v, input logic [1:0] c, input logic l,
                              input logic zz, input logic o);
    vec_t t;
    t.x = xi; t.mask = m; t.rdy = r; t.v = v; t.ch = c; t.lvl = l; t.z = zz; t.ovf = o;
    return t;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_offer(input string name, input logic [1:0] c, input logic l);
    chk({name, ".valid"}, 8'(evt.evt_valid), 8'd1);
    chk({name, ".ch"}, 8'(evt.evt_ch), 8'(c));
    chk({name, ".level"}, 8'(evt.evt_level), 8'(l));
  endtask

  task automatic run_row(input vec_t v, input string tag, input int i);
    string n;
    x = v.x;
    en_mask = v.mask;
    evt.evt_ready = v.rdy;
    step();
    n = $sformatf("%s[%0d]", tag, i);
    chk({n, ".valid"}, 8'(evt.evt_valid), 8'(v.v));
    if (v.v) begin
      chk({n, ".ch"}, 8'(evt.evt_ch), 8'(v.ch));
      chk({n, ".level"}, 8'(evt.evt_level), 8'(v.lvl));
    end
    chk({n, ".z"}, 8'(z), 8'(v.z));
    chk({n, ".overflow"}, 8'(overflow), 8'(v.ovf));
  endtask

  task automatic do_reset();
    MR = 1'b0;
    x = 4'h0;
    en_mask = 4'hF;
    evt.evt_ready = 1'b0;
    ovf_clr = 1'b0;
    step();
    step();
    MR = 1'b1;
  endtask

  initial begin
    MR = 1'b1; x = 4'h0; en_mask = 4'hF; ovf_clr = 1'b0; evt.evt_ready = 1'b0;
    #2 MR = 1'b0;
    #1;
    chk("reset.valid", 8'(evt.evt_valid), 8'd0);
    chk("reset.z", 8'(z), 8'd0);
    chk("reset.overflow", 8'(overflow), 8'd0);

    // Latency: x[0] rises before edge 0, stable at 4, offer at 5, accepted at 6.
    for (int i = 0; i < 8; i++) tab_a[i] = mk(4'h1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tab_a[5] = mk(4'h1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    tab_a[6].z = 1'b1;
    tab_a[7].z = 1'b1;

    // Round robin: all four flip together, then ch0 and ch3 fall after ptr wrapped.
    for (int i = 0; i < 23; i++)
      tab_b[i] = mk((i < 13) ? 4'hF : 4'h6, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, (i >= 5), 1'b0);
    tab_b[5]  = mk(4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    tab_b[7]  = mk(4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    tab_b[9]  = mk(4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    tab_b[11] = mk(4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    tab_b[18] = mk(4'h6, 4'hF, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    tab_b[20] = mk(4'h6, 4'hF, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);

    step();
    step();
    MR = 1'b1;
    for (int i = 0; i < 8; i++) run_row(tab_a[i], "lat", i);

    // Asynchronous reset while ch1 is offered.
    evt.evt_ready = 1'b0;
    x = 4'h3;
    repeat (6) step();
    chk_offer("mr.pre", 2'd1, 1'b1);
    chk("mr.pre.z", 8'(z), 8'd1);
    #3 MR = 1'b0;
    #1;
    chk("mr.async.valid", 8'(evt.evt_valid), 8'd0);
    chk("mr.async.z", 8'(z), 8'd0);
    do_reset();

    for (int i = 0; i < 23; i++) run_row(tab_b[i], "rr", i);

    // Glitch: two-cycle pulse on x[2] is rejected.
    do_reset();
    evt.evt_ready = 1'b1;
    x = 4'h4;
    step();
    step();
    x = 4'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("glitch[%0d].valid", i), 8'(evt.evt_valid), 8'd0);
      chk($sformatf("glitch[%0d].z", i), 8'(z), 8'd0);
    end

    // Three-cycle pulse on x[3] is accepted, and so is its trailing edge.
    x = 4'h8;
    repeat (3) step();
    x = 4'h0;
    step();
    step();
    chk("pulse3.k4.valid", 8'(evt.evt_valid), 8'd0);
    step();
    chk_offer("pulse3.rise", 2'd3, 1'b1);
    chk("pulse3.z", 8'(z), 8'd1);
    step();
    chk("pulse3.k6.valid", 8'(evt.evt_valid), 8'd0);
    step();
    chk("pulse3.k7.valid", 8'(evt.evt_valid), 8'd0);
    step();
    chk_offer("pulse3.fall", 2'd3, 1'b0);
    step();

    // Backpressure: ch1 stalled ten cycles, re-flips during the stall,
    // and a flip landing on the handshake edge keeps it pending.
    evt.evt_ready = 1'b0;
    x = 4'h2;
    repeat (6) step();
    chk_offer("bp.offer", 2'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) x = 4'h0;
      if (i == 6) x = 4'h2;
      step();
      chk_offer($sformatf("bp.stall[%0d]", i), 2'd1, 1'b1);
      chk($sformatf("bp.stall[%0d].overflow", i), 8'(overflow), (i >= 5) ? 8'd1 : 8'd0);
    end
    evt.evt_ready = 1'b1;
    step();
    chk("bp.hs.valid", 8'(evt.evt_valid), 8'd0);
    step();
    chk_offer("bp.reoffer", 2'd1, 1'b1);
    step();
    chk("bp.done.valid", 8'(evt.evt_valid), 8'd0);
    step();
    chk("bp.idle.valid", 8'(evt.evt_valid), 8'd0);

    // Overflow clear: lone clear, clear colliding with a set, lone clear.
    evt.evt_ready = 1'b0;
    x = 4'h0;
    repeat (6) step();
    chk_offer("ovf.offer", 2'd1, 1'b0);
    ovf_clr = 1'b1;
    x = 4'h2;
    step();
    ovf_clr = 1'b0;
    chk("ovf.clr1", 8'(overflow), 8'd0);
    repeat (3) step();
    chk("ovf.pre", 8'(overflow), 8'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf.set_wins", 8'(overflow), 8'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf.clr2", 8'(overflow), 8'd0);
    evt.evt_ready = 1'b1;
    step();
    chk("ovf.hs.valid", 8'(evt.evt_valid), 8'd0);
    step();
    chk("ovf.idle.valid", 8'(evt.evt_valid), 8'd0);

    // Masking: ch0 disabled toggles silently and does not drive z.
    x = 4'h0;
    repeat (8) step();
    chk("mask.base.z", 8'(z), 8'd0);
    en_mask = 4'hE;
    x = 4'h1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("mask0[%0d].valid", i), 8'(evt.evt_valid), 8'd0);
      chk($sformatf("mask0[%0d].z", i), 8'(z), 8'd0);
    end
    en_mask = 4'hF;
    step();
    chk("mask.en.z", 8'(z), 8'd1);
    chk("mask.en.valid", 8'(evt.evt_valid), 8'd0);

    // ch2 pending is dropped when its mask clears in IDLE before the grant.
    x = 4'h5;
    repeat (5) step();
    chk("mask2.set.valid", 8'(evt.evt_valid), 8'd0);
    en_mask = 4'hB;
    step();
    chk("mask2.clr.valid", 8'(evt.evt_valid), 8'd0);
    en_mask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mask2.after[%0d].valid", i), 8'(evt.evt_valid), 8'd0);
    end
    chk("mask2.z", 8'(z), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
